wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16), meaning the number of writeback entries buffered.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_reg input 5, in_data input 64: the writeback request handshake.
REQ-005 SHALL have port wr_stall  input  1  pauses issue to the register file.
REQ-006 SHALL have ports RegWrite output 1, WriteRegister output 5, WriteData output 64, driving the regfile write port.
REQ-007 SHALL have ports ReadRegister1, ReadRegister2 input 5 (copies of regfile read addresses); fwd_hit1, fwd_hit2 output 1; fwd_data1, fwd_data2 output 64.
REQ-008 SHALL have ports count output $clog2(DEPTH)+1 (occupancy) and empty output 1.

Function
REQ-009 SHALL be a circular FIFO of {reg[4:0], data[63:0]} entries with head/tail pointers wrapping modulo DEPTH.
REQ-010 SHALL accept a request when in_valid && in_ready at posedge; in_ready = (count < DEPTH), independent of same-cycle pop.
REQ-011 SHALL consume but not enqueue an accepted request with in_reg == 31 (XZR); count unchanged by it.
REQ-012 SHALL drive RegWrite = !empty && !wr_stall combinationally; WriteRegister/WriteData = head entry; when RegWrite == 0, WriteRegister and WriteData SHALL hold head values, or 31 and 0 if empty.
REQ-013 SHALL pop the head at posedge when RegWrite == 1 (the regfile captures on the same edge).
REQ-014 SHALL support push and pop in the same cycle: count unchanged, both pointers advance.
REQ-015 SHALL never enqueue into an empty queue and issue it in the same cycle: minimum enqueue-to-RegWrite latency is 1 cycle.
REQ-016 SHALL preserve order: entries issue in acceptance order, including multiple writes to the same register.
REQ-017 SHALL drive empty = (count == 0); count SHALL never exceed DEPTH or underflow.

Reset
REQ-018 SHALL, on reset assertion, immediately clear head, tail and count; empty = 1, in_ready = 1, RegWrite = 0, WriteRegister = 31, WriteData = 0, fwd_hit* = 0, fwd_data* = 0.
REQ-019 SHALL discard all pending entries on reset mid-operation; no partial write is issued after reset asserts.
REQ-020 SHALL ignore in_valid while reset is high.

Configuration
REQ-021 SHALL compile the forwarding logic only when macro WB_QUEUE_BYPASS_EN is defined.
REQ-022 With WB_QUEUE_BYPASS_EN: fwd_hitN = 1 iff any valid entry has reg == ReadRegisterN (N = 1, 2); fwd_dataN = data of the youngest matching entry; ReadRegisterN == 31 never hits; purely combinational, valid entries only.
REQ-023 Without WB_QUEUE_BYPASS_EN: fwd_hit1/2 and fwd_data1/2 SHALL be tied to 0; ports remain present.

Structure
REQ-024 SHALL import package wb_pkg holding XLEN = 64, NREG = 32, REG_ZERO = 5'd31 and typedef wb_entry_t {reg, data}.
REQ-025 SHALL place the youngest-match search in one sub-module, wb_fwd_match, instanced twice (one per read port).

Verification
REQ-026 Reset mid-queue: 3 entries pending, pulse reset -> count = 0, RegWrite = 0, WriteRegister = 31 immediately, nothing issued after.
REQ-027 Ordering: push (X1, 0xA), (X2, 0xB), (X1, 0xC) with wr_stall = 0 -> RegWrite in 3 consecutive cycles with X1 = 0xA, X2 = 0xB, X1 = 0xC.
REQ-028 Full: wr_stall = 1, push DEPTH = 4 entries -> count = 4, in_ready = 0; fifth request held until wr_stall drops and one pop completes.
REQ-029 XZR: push (X31, 0xA0) then (X3, 0x5) -> only X3 is issued; count peaks at 1.
REQ-030 Bypass (WB_QUEUE_BYPASS_EN): stall, queue (X4, 0x11) then (X4, 0x22), ReadRegister1 = 4, ReadRegister2 = 31 -> fwd_hit1 = 1, fwd_data1 = 0x22, fwd_hit2 = 0; without the macro both hits = 0.
REQ-031 Simultaneous push/pop at count = 2 for 10 cycles -> count stays 2, issue order matches push order across pointer wrap.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Provides XLEN, NREG, REG_ZERO (XZR encoding) and the queued entry payload type.
package wb_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = $clog2(NREG);

  localparam logic [REG_W-1:0] REG_ZERO = 5'd31;

  // Queued writeback: destination register and value ("reg" is a keyword, hence wreg)
  typedef struct packed {
    logic [REG_W-1:0] wreg;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the valid window of the writeback queue.
// Ports:
//   entries  - queue storage (indexed by physical slot)
//   head     - slot of the oldest valid entry
//   count    - number of valid entries starting at head
//   rd_reg   - register being read; XZR never hits
//   hit      - some valid entry targets rd_reg
//   data     - data of the youngest such entry (0 when no hit)
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t               entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [REG_W-1:0]         rd_reg,
  output logic                     hit,
  output logic [XLEN-1:0]          data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; the last match seen is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned age = 0; age < DEPTH; age++) begin
      idx = head + PTR_W'(age);
      if ((CNT_W'(age) < count) && (rd_reg != REG_ZERO) &&
          (entries[idx].wreg == rd_reg)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: circular FIFO of {reg, data} writebacks feeding the
// register file write port, with optional read forwarding.
// Ports:
//   clk, reset                      - clock, async active-high reset
//   in_valid/in_ready/in_reg/in_data - writeback request handshake
//   wr_stall                        - holds issue to the register file
//   RegWrite/WriteRegister/WriteData - register file write port (combinational)
//   ReadRegister1/2, fwd_hit1/2, fwd_data1/2 - forwarding lookups
//   count, empty                    - occupancy
// Build option: define WB_QUEUE_BYPASS_EN to include forwarding logic;
// otherwise fwd_* outputs are tied to 0.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_reg,
  input  logic [63:0]            in_data,
  input  logic                   wr_stall,
  output logic                   RegWrite,
  output logic [4:0]             WriteRegister,
  output logic [63:0]            WriteData,
  input  logic [4:0]             ReadRegister1,
  input  logic [4:0]             ReadRegister2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [63:0]            fwd_data1,
  output logic [63:0]            fwd_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;

  assign empty    = (count == '0);
  assign in_ready = (count < CNT_W'(DEPTH));

  // XZR writes are accepted but dropped.
  assign push = in_valid && in_ready && (in_reg != REG_ZERO);
  // Head is only visible after it has been registered, so an entry pushed
  // into an empty queue issues no earlier than the following cycle.
  assign pop  = RegWrite;

  assign RegWrite      = !empty && !wr_stall;
  assign WriteRegister = empty ? REG_ZERO : mem[head].wreg;
  assign WriteData     = empty ? '0 : mem[head].data;

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; slots outside the valid window are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{wreg: in_reg, data: in_data};
  end

`ifdef WB_QUEUE_BYPASS_EN
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (mem),
    .head    (head),
    .count   (count),
    .rd_reg  (ReadRegister1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (mem),
    .head    (head),
    .count   (count),
    .rd_reg  (ReadRegister2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );
`else
  // Forwarding not built; read addresses are intentionally left unconsumed.
  logic unused_rd;
  assign unused_rd = ^{ReadRegister1, ReadRegister2};

  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue (DEPTH = 4) using an issue scoreboard.
module tb_wb_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [63:0] in_data;
  logic        wr_stall;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [63:0] fwd_data1;
  logic [63:0] fwd_data2;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fails  = 0;

  wb_entry_t exp_q[$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_data       (in_data),
    .wr_stall      (wr_stall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .count         (count),
    .empty         (empty)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare issued writes at negedge, then record accepted pushes.
  always @(negedge clk) begin
    if (!reset) begin
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_issue", {59'd0, WriteRegister}, 64'd0);
        end else begin
          wb_entry_t e;
          e = exp_q.pop_front();
          check_eq("issue_reg", {59'd0, WriteRegister}, {59'd0, e.wreg});
          check_eq("issue_data", WriteData, e.data);
        end
      end
      if (in_valid && in_ready && in_reg != 5'd31)
        exp_q.push_back('{wreg: in_reg, data: in_data});
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic [4:0] r, input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!empty && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", {63'd0, empty}, 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    wr_stall = 1'b0; ReadRegister1 = '0; ReadRegister2 = '0;
    #2;
    check_eq("rst_count",   {61'd0, count}, 64'd0);
    check_eq("rst_empty",   {63'd0, empty}, 64'd1);
    check_eq("rst_ready",   {63'd0, in_ready}, 64'd1);
    check_eq("rst_regwr",   {63'd0, RegWrite}, 64'd0);
    check_eq("rst_wreg",    {59'd0, WriteRegister}, 64'd31);
    check_eq("rst_wdata",   WriteData, 64'd0);
    check_eq("rst_fwd_hit1", {63'd0, fwd_hit1}, 64'd0);
    check_eq("rst_fwd_data1", fwd_data1, 64'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Ordering, including repeated writes to one register.
    send(5'd1, 64'hA);
    check_eq("lat1_regwr", {63'd0, RegWrite}, 64'd1);
    check_eq("lat1_wreg",  {59'd0, WriteRegister}, 64'd1);
    send(5'd2, 64'hB);
    send(5'd1, 64'hC);
    check_eq("ord_last_regwr", {63'd0, RegWrite}, 64'd1);
    check_eq("ord_last_data",  WriteData, 64'hC);
    step();
    check_eq("ord_done_empty", {63'd0, empty}, 64'd1);

    // XZR is consumed but never queued.
    send(5'd31, 64'hA0);
    check_eq("xzr_count", {61'd0, count}, 64'd0);
    send(5'd3, 64'h5);
    check_eq("xzr_x3_count", {61'd0, count}, 64'd1);
    check_eq("xzr_x3_wreg", {59'd0, WriteRegister}, 64'd3);
    wait_empty();

    // Full queue holds the fifth request until a pop frees a slot.
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(5'(5 + i), 64'(256 + i));
    check_eq("full_count", {61'd0, count}, 64'd4);
    check_eq("full_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_reg = 5'd9; in_data = 64'h109;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("full_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    wr_stall = 1'b0;
    #1;
    check_eq("full_ready_on_pop", {63'd0, in_ready}, 64'd0);
    step();
    check_eq("full_after_pop_count", {61'd0, count}, 64'd3);
    check_eq("full_after_pop_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check_eq("full_push_pop_count", {61'd0, count}, 64'd3);
    wait_empty();

    // Forwarding picks the youngest match; XZR never hits.
    wr_stall = 1'b1;
    send(5'd4, 64'h11);
    send(5'd4, 64'h22);
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd31;
    #1;
`ifdef WB_QUEUE_BYPASS_EN
    check_eq("fwd_hit1",  {63'd0, fwd_hit1}, 64'd1);
    check_eq("fwd_data1", fwd_data1, 64'h22);
`else
    check_eq("fwd_hit1",  {63'd0, fwd_hit1}, 64'd0);
    check_eq("fwd_data1", fwd_data1, 64'd0);
`endif
    check_eq("fwd_hit2",  {63'd0, fwd_hit2}, 64'd0);
    ReadRegister2 = 5'd6;
    #1;
    check_eq("fwd_miss2", {63'd0, fwd_hit2}, 64'd0);

    // Reset with three pending entries discards them at once.
    send(5'd6, 64'h33);
    check_eq("pre_rst_count", {61'd0, count}, 64'd3);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_eq("mid_rst_count", {61'd0, count}, 64'd0);
    check_eq("mid_rst_regwr", {63'd0, RegWrite}, 64'd0);
    check_eq("mid_rst_wreg",  {59'd0, WriteRegister}, 64'd31);
    check_eq("mid_rst_fwd1",  {63'd0, fwd_hit1}, 64'd0);
    in_valid = 1'b1; in_reg = 5'd7; in_data = 64'h77;
    wr_stall = 1'b0;
    step(); step();
    check_eq("rst_ignores_valid", {61'd0, count}, 64'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_rst_regwr", {63'd0, RegWrite}, 64'd0);
    end

    // Steady push+pop at occupancy 2 across pointer wrap.
    wr_stall = 1'b1;
    send(5'd10, 64'h1000);
    send(5'd11, 64'h1001);
    wr_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_reg   = 5'(12 + i);
      in_data  = 64'(32'h2000 + i);
      step();
      check_eq("pp_count", {61'd0, count}, 64'd2);
    end
    in_valid = 1'b0;
    wait_empty();
    step();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
